// File: rtl/bh1750_target_model.sv
// BH1750 light-sensor I2C target model: answers at 0x23/0x5C, latches command bytes, returns a 16-bit sample.
// Optional bus-hang recovery: define BH1750_TARGET_TIMEOUT_EN to enable the SCL inactivity timeout.
module bh1750_target_model #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        sys_clk,
    input  logic        _rst,
    input  logic        SCL,
    inout  wire         SDA,
    input  logic        addr_sel,
    input  logic [15:0] sample,
    output logic [7:0]  opcode,
    output logic        cmd_valid,
    output logic        powered,
    output logic        rd_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("bh1750_target_model: illegal parameter value");
    end

    localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic        scl_prev_q, sda_prev_q;
    logic [2:0]  settle_q, settle_d;
    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d, tx_q, tx_d;
    logic [1:0]  byte_idx_q, byte_idx_d, next_idx;
    logic        rw_q, rw_d, first_q, first_d, sda_oe_q, sda_oe_d;
    logic [15:0] shadow_q, shadow_d;
    logic [7:0]  opcode_q, opcode_d, rx_byte;
    logic        cmd_valid_q, cmd_valid_d, powered_q, powered_d;
    logic        rd_done_q, rd_done_d, busy_q, busy_d;
    logic        sda_in, scl_s, sda_s, settled;
    logic        scl_rise, scl_fall, start_c, stop_c;
    logic [6:0]  dev_addr;

`ifdef BH1750_TARGET_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
    assign sda_in   = SDA;
    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    // Edges are ignored until the synchronizers have refilled after reset, so a bus caught mid-transfer cannot fake a START.
    assign settled  = (settle_q == SETTLE);
    assign scl_rise = settled & scl_s & ~scl_prev_q;
    assign scl_fall = settled & ~scl_s & scl_prev_q;
    assign start_c  = settled & scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_c   = settled & scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign dev_addr = addr_sel ? 7'h5C : 7'h23;

    assign opcode    = opcode_q;
    assign cmd_valid = cmd_valid_q;
    assign powered   = powered_q;
    assign rd_done   = rd_done_q;
    assign busy      = busy_q;

    function automatic logic [7:0] rd_byte(input logic [1:0] idx, input logic [15:0] sh);
        case (idx)
            2'd0:    rd_byte = sh[15:8];
            2'd1:    rd_byte = sh[7:0];
            default: rd_byte = 8'hFF;
        endcase
    endfunction

    always_comb begin
        scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], SCL};
        sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        settle_d    = settled ? settle_q : settle_q + 3'd1;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        byte_idx_d  = byte_idx_q;
        rw_d        = rw_q;
        first_d     = first_q;
        sda_oe_d    = sda_oe_q;
        shadow_d    = shadow_q;
        opcode_d    = opcode_q;
        cmd_valid_d = 1'b0;
        powered_d   = powered_q;
        rd_done_d   = 1'b0;
        busy_d      = busy_q;
        rx_byte     = {shift_q[6:0], sda_s};
        next_idx    = (byte_idx_q == 2'd2) ? 2'd2 : byte_idx_q + 2'd1;
`ifdef BH1750_TARGET_TIMEOUT_EN
        to_cnt_d    = (state_q == S_IDLE || scl_rise || scl_fall) ? '0 : to_cnt_q + 1'b1;
`endif

        if (start_c || stop_c) begin
            if (state_q == S_RD_DATA || state_q == S_RD_ACK) rd_done_d = 1'b1;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = start_c ? S_ADDR : S_IDLE;
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        if (rx_byte[7:1] == dev_addr) begin
                            state_d    = S_ADDR_ACK;
                            rw_d       = rx_byte[0];
                            busy_d     = 1'b1;
                            first_d    = 1'b1;
                            byte_idx_d = 2'd0;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                // Count 8 marks "ACK not yet driven", 9 marks "ACK on the bus".
                S_ADDR_ACK, S_WR_ACK: if (scl_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = 4'd9;
                        if (state_q == S_ADDR_ACK && rw_q) shadow_d = powered_q ? sample : 16'h0000;
                    end else begin
                        bit_cnt_d = 4'd0;
                        if (state_q == S_ADDR_ACK && rw_q) begin
                            state_d  = S_RD_DATA;
                            tx_d     = rd_byte(2'd0, shadow_q);
                            sda_oe_d = ~shadow_q[15];
                        end else begin
                            state_d  = S_WR_DATA;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                S_WR_DATA: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = S_WR_ACK;
                        if (first_q) begin
                            first_d     = 1'b0;
                            opcode_d    = rx_byte;
                            cmd_valid_d = 1'b1;
                            case (rx_byte)
                                8'h00: powered_d = 1'b0;
                                8'h01, 8'h10, 8'h11, 8'h13, 8'h20, 8'h21, 8'h23: powered_d = 1'b1;
                                8'h07: if (powered_q) shadow_d = 16'h0000;
                                default: ;
                            endcase
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_RD_ACK;
                        end else begin
                            tx_d     = {tx_q[6:0], 1'b1};
                            sda_oe_d = ~tx_q[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            byte_idx_d = next_idx;
                            tx_d       = rd_byte(next_idx, shadow_q);
                        end else begin
                            rd_done_d = 1'b1;
                            state_d   = S_IGNORE;
                        end
                    end
                    if (scl_fall) begin
                        state_d   = S_RD_DATA;
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = ~tx_q[7];
                    end
                end
                default: ;
            endcase
`ifdef BH1750_TARGET_TIMEOUT_EN
            if (state_q != S_IDLE && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                state_d  = S_IDLE;
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
                to_cnt_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            settle_q    <= 3'd0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'hFF;
            byte_idx_q  <= 2'd0;
            rw_q        <= 1'b0;
            first_q     <= 1'b0;
            sda_oe_q    <= 1'b0;
            shadow_q    <= 16'h0000;
            opcode_q    <= 8'h00;
            cmd_valid_q <= 1'b0;
            powered_q   <= 1'b0;
            rd_done_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BH1750_TARGET_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_s;
            sda_prev_q  <= sda_s;
            settle_q    <= settle_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            byte_idx_q  <= byte_idx_d;
            rw_q        <= rw_d;
            first_q     <= first_d;
            sda_oe_q    <= sda_oe_d;
            shadow_q    <= shadow_d;
            opcode_q    <= opcode_d;
            cmd_valid_q <= cmd_valid_d;
            powered_q   <= powered_d;
            rd_done_q   <= rd_done_d;
            busy_q      <= busy_d;
`ifdef BH1750_TARGET_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_bh1750_target_model.sv
// Bench for bh1750_target_model: bit-banged I2C master plus a transaction-level model of the sensor.
module tb_bh1750_target_model;

    localparam int Q = 10;   // sys_clk cycles per quarter SCL period

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        master_sda = 1'b1;
    logic        addr_sel = 1'b0;
    logic [15:0] sample = 16'h0000;
    wire  [7:0]  opcode;
    wire         cmd_valid, powered, rd_done, busy;
    wire         sda_bus;

    pullup (sda_bus);
    assign sda_bus = master_sda ? 1'bz : 1'b0;

    int   nvec = 0;
    int   nerr = 0;
    int   cmd_cnt = 0;
    int   done_cnt = 0;
    logic check_en = 1'b0;
    logic dut_drove = 1'b0;
    logic [7:0] exp_opcode = 8'h00;
    logic       exp_powered = 1'b0;
    logic [7:0] rd_bytes [0:3];

    always #5 sys_clk = ~sys_clk;

    bh1750_target_model #(.SYNC_STAGES(2), .TIMEOUT_CYC(100)) dut (
        .sys_clk(sys_clk), ._rst(rst_n), .SCL(scl), .SDA(sda_bus), .addr_sel(addr_sel),
        .sample(sample), .opcode(opcode), .cmd_valid(cmd_valid), .powered(powered),
        .rd_done(rd_done), .busy(busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sensor model: command bytes drive opcode/power; reads return the powered sample, then 0xFF.
    function automatic logic [6:0] model_addr();
        return addr_sel ? 7'h5C : 7'h23;
    endfunction

    task automatic model_cmd(input logic [7:0] c);
        exp_opcode = c;
        if (c == 8'h00) exp_powered = 1'b0;
        else if (c inside {8'h01, 8'h10, 8'h11, 8'h13, 8'h20, 8'h21, 8'h23}) exp_powered = 1'b1;
    endtask

    function automatic logic [7:0] model_rd(input int idx, input logic [15:0] shadow);
        if (idx == 0) return shadow[15:8];
        if (idx == 1) return shadow[7:0];
        return 8'hFF;
    endfunction

    // Pulse counting, unexpected-drive detection and idle-time comparison against the model.
    always @(negedge sys_clk) begin
        if (sda_bus === 1'b0 && master_sda === 1'b1) dut_drove = 1'b1;
        if (cmd_valid === 1'b1) cmd_cnt++;
        if (rd_done === 1'b1) done_cnt++;
        if (check_en) begin
            checkOutput("idle_opcode", opcode, exp_opcode);
            checkOutput("idle_powered", powered, exp_powered);
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_sda", sda_bus, 1);
        end
    end

    task automatic quarter();
        #(Q * 10);
    endtask

    task automatic idle_gap();
        check_en = 1'b1;
        repeat (4) @(negedge sys_clk);
        check_en = 1'b0;
    endtask

    task automatic i2c_start();
        master_sda = 1'b1; quarter();
        scl = 1'b1;        quarter();
        master_sda = 1'b0; quarter();
        scl = 1'b0;        quarter();
    endtask

    task automatic i2c_stop();
        master_sda = 1'b0; quarter();
        scl = 1'b1;        quarter();
        master_sda = 1'b1; quarter();
    endtask

    task automatic clock_bit(input logic b, output logic rx);
        master_sda = b; quarter();
        scl = 1'b1;     quarter();
        rx = sda_bus;   quarter();
        scl = 1'b0;     quarter();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack_n);
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], dummy);
        clock_bit(1'b1, ack_n);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, d[i]);
        clock_bit(nack, dummy);
    endtask

    // Full write transaction: address, command byte, optional trailing byte, STOP.
    task automatic applyStimulus(input logic [7:0] addr_byte, input logic [7:0] cmd,
                                 input logic send_extra, input logic [7:0] extra, input string tag);
        logic ack_n;
        logic match;
        int   cmd0;
        match = (addr_byte[7:1] == model_addr());
        cmd0 = cmd_cnt;
        dut_drove = 1'b0;
        i2c_start();
        write_byte(addr_byte, ack_n);
        checkOutput({tag, "_addr_ack"}, ack_n, match ? 0 : 1);
        if (match) checkOutput({tag, "_busy"}, busy, 1);
        write_byte(cmd, ack_n);
        checkOutput({tag, "_cmd_ack"}, ack_n, match ? 0 : 1);
        if (send_extra) begin
            write_byte(extra, ack_n);
            checkOutput({tag, "_extra_ack"}, ack_n, match ? 0 : 1);
        end
        i2c_stop();
        if (match) model_cmd(cmd);
        else checkOutput({tag, "_no_drive"}, dut_drove, 0);
        checkOutput({tag, "_cmd_pulses"}, cmd_cnt - cmd0, match ? 1 : 0);
        idle_gap();
    endtask

    // Read transaction: ACK every byte except the last, which is NACKed.
    task automatic readTxn(input int nbytes, input string tag);
        logic [15:0] shadow;
        logic        ack_n;
        logic [7:0]  d;
        int          done0;
        shadow = exp_powered ? sample : 16'h0000;
        done0 = done_cnt;
        i2c_start();
        write_byte({model_addr(), 1'b1}, ack_n);
        checkOutput({tag, "_addr_ack"}, ack_n, 0);
        for (int i = 0; i < nbytes; i++) begin
            read_byte(i == nbytes - 1, d);
            rd_bytes[i] = d;
            checkOutput($sformatf("%s_byte%0d", tag, i), d, model_rd(i, shadow));
        end
        i2c_stop();
        idle_gap();
        checkOutput({tag, "_rd_done"}, done_cnt - done0, 1);
    endtask

    initial begin
        logic       ack_n;
        logic       dummy;
        logic [7:0] d;
        logic [7:0] v;
        int         done0;
        int         cmd0;

        repeat (3) @(negedge sys_clk);
        checkOutput("rst_opcode", opcode, 8'h00);
        checkOutput("rst_powered", powered, 0);
        checkOutput("rst_cmd_valid", cmd_valid, 0);
        checkOutput("rst_rd_done", rd_done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sda", sda_bus, 1);
        rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);

        applyStimulus(8'h46, 8'h10, 1'b0, 8'h00, "w10");
        checkOutput("lit_w10_opcode", opcode, 8'h10);
        checkOutput("lit_w10_powered", powered, 1);

        sample = 16'hA5C3;
        readTxn(2, "rdA5C3");
        checkOutput("lit_rd_b0", rd_bytes[0], 8'hA5);
        checkOutput("lit_rd_b1", rd_bytes[1], 8'hC3);
        checkOutput("lit_rd_busy", busy, 0);

        addr_sel = 1'b1;
        applyStimulus(8'h46, 8'h00, 1'b0, 8'h00, "nomatch");
        checkOutput("lit_nomatch_opcode", opcode, 8'h10);
        applyStimulus(8'hB8, 8'h42, 1'b0, 8'h00, "addr5c");
        checkOutput("lit_addr5c_opcode", opcode, 8'h42);
        checkOutput("lit_addr5c_powered", powered, 1);
        addr_sel = 1'b0;

        applyStimulus(8'h46, 8'h13, 1'b1, 8'h00, "extra");
        checkOutput("lit_extra_powered", powered, 1);

        applyStimulus(8'h46, 8'h00, 1'b0, 8'h00, "pwroff");
        sample = 16'h1234;
        readTxn(3, "rdoff");
        checkOutput("lit_off_b0", rd_bytes[0], 8'h00);
        checkOutput("lit_off_b1", rd_bytes[1], 8'h00);
        checkOutput("lit_off_b2", rd_bytes[2], 8'hFF);
        checkOutput("lit_off_powered", powered, 0);

        // Write cut by STOP halfway through the command byte.
        v = 8'h23;
        i2c_start();
        write_byte(8'h46, ack_n);
        checkOutput("partial_addr_ack", ack_n, 0);
        for (int i = 7; i >= 4; i--) clock_bit(v[i], dummy);
        i2c_stop();
        idle_gap();

        // Repeated START in the middle of the second read byte.
        applyStimulus(8'h46, 8'h01, 1'b0, 8'h00, "pwron");
        sample = 16'h12F0;
        done0 = done_cnt;
        i2c_start();
        write_byte(8'h47, ack_n);
        checkOutput("rs_addr_ack", ack_n, 0);
        read_byte(1'b0, d);
        checkOutput("rs_byte0", d, 8'h12);
        i2c_start();
        checkOutput("rs_rd_done", done_cnt - done0, 1);
        write_byte(8'h46, ack_n);
        checkOutput("rs_addr2_ack", ack_n, 0);
        write_byte(8'h11, ack_n);
        checkOutput("rs_cmd_ack", ack_n, 0);
        i2c_stop();
        model_cmd(8'h11);
        idle_gap();

        // SCL stalls low mid-byte for well over 100 cycles.
        v = 8'h21;
        cmd0 = cmd_cnt;
        i2c_start();
        write_byte(8'h46, ack_n);
        checkOutput("hold_addr_ack", ack_n, 0);
        for (int i = 7; i >= 4; i--) clock_bit(v[i], dummy);
        repeat (130) @(negedge sys_clk);
        for (int i = 3; i >= 0; i--) clock_bit(v[i], dummy);
        clock_bit(1'b1, ack_n);
        i2c_stop();
`ifdef BH1750_TARGET_TIMEOUT_EN
        checkOutput("hold_cmd_ack", ack_n, 1);
        checkOutput("hold_cmd_pulses", cmd_cnt - cmd0, 0);
`else
        checkOutput("hold_cmd_ack", ack_n, 0);
        checkOutput("hold_cmd_pulses", cmd_cnt - cmd0, 1);
        model_cmd(8'h21);
`endif
        idle_gap();

        // Reset asserted while the target is driving a 0 data bit.
        sample = 16'hF0F0;
        i2c_start();
        write_byte(8'h47, ack_n);
        checkOutput("mr_addr_ack", ack_n, 0);
        for (int i = 0; i < 4; i++) begin
            clock_bit(1'b1, d[0]);
            checkOutput($sformatf("mr_bit%0d", i), d[0], 1);
        end
        checkOutput("mr_pre_drive", sda_bus, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("mr_sda", sda_bus, 1);
        checkOutput("mr_opcode", opcode, 8'h00);
        checkOutput("mr_powered", powered, 0);
        checkOutput("mr_busy", busy, 0);
        checkOutput("mr_cmd_valid", cmd_valid, 0);
        checkOutput("mr_rd_done", rd_done, 0);
        exp_opcode = 8'h00;
        exp_powered = 1'b0;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        i2c_stop();
        idle_gap();
        applyStimulus(8'h46, 8'h01, 1'b0, 8'h00, "post_rst");
        readTxn(2, "post_rst_rd");
        checkOutput("lit_post_b0", rd_bytes[0], 8'hF0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bh1750_target_model.md
BH1750_TARGET_MODEL -- requirements
Module: bh1750_target_model

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth for SCL/SDA (legal range 2..4).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, sys_clk cycles of SCL inactivity before forced idle (used only under REQ-030).
REQ-003 SHALL have port sys_clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port _rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SCL  input  1  I2C clock from the bus master; the block never drives it.
REQ-006 SHALL have port SDA  inout  1  I2C data; driven only to 0, otherwise high-Z.
REQ-007 SHALL have port addr_sel  input  1  ADDR pin: 0 selects 7-bit address 0x23, 1 selects 0x5C.
REQ-008 SHALL have port sample  input  16  light value returned to the master.
REQ-009 SHALL have port opcode  output  8  last accepted command byte.
REQ-010 SHALL have port cmd_valid  output  1  one-cycle pulse when opcode updates.
REQ-011 SHALL have port powered  output  1  1 = powered on (opcode 0x01 or any measurement opcode seen since the last 0x00).
REQ-012 SHALL have port rd_done  output  1  one-cycle pulse when a read transaction ends (master NACK or STOP).
REQ-013 SHALL have port busy  output  1  high from address match until STOP/START/return to IDLE.

Function
REQ-014 SCL/SDA SHALL pass through SYNC_STAGES flops; all edge detection uses the synchronized values; detection latency SYNC_STAGES+1 cycles.
REQ-015 START SHALL be synchronized SDA falling while synchronized SCL high; STOP SHALL be SDA rising while SCL high; both are recognized in any state.
REQ-016 FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-017 START (including repeated START) SHALL enter ADDR with the bit counter cleared; STOP SHALL enter IDLE and release SDA.
REQ-018 Bits SHALL be sampled on SCL rising, MSB first; 8 bits form each byte.
REQ-019 ADDR: byte[7:1] equal to the selected address SHALL go to ADDR_ACK; mismatch SHALL go to IGNORE (no SDA drive until next START/STOP).
REQ-020 ACK SHALL be driven low from the SCL falling edge after bit 8 until the following SCL falling edge.
REQ-021 On address match with R/W=1, sample SHALL be latched into a 16-bit shadow register at the ACK; on R/W=0, WR_DATA follows.
REQ-022 WR_DATA: each received byte SHALL be ACKed; the first byte after the address SHALL update opcode and pulse cmd_valid in the cycle after bit 8 sampling; later bytes in the same transaction SHALL be ACKed and discarded.
REQ-023 Opcode 0x00 SHALL clear powered; 0x01 and 0x10/0x11/0x13/0x20/0x21/0x23 SHALL set powered; 0x07 SHALL clear the shadow register to 0 only while powered=1; other values SHALL update opcode without changing powered.
REQ-024 RD_DATA: output bits SHALL change on SCL falling; bytes are shadow[15:8], then shadow[7:0], then 0xFF for every further byte; a data bit of 1 releases SDA.
REQ-025 RD_ACK: master ACK (SDA=0 at SCL rising) SHALL continue with the next byte; NACK SHALL pulse rd_done and enter IGNORE until STOP/START.
REQ-026 When powered=0 the address SHALL still be ACKed and reads SHALL return 0x0000 for the two data bytes.
REQ-027 STOP or START arriving mid-read SHALL pulse rd_done once; mid-byte writes SHALL be discarded without updating opcode.

Reset
REQ-028 _rst low SHALL asynchronously force state IDLE, SDA high-Z, opcode=0x00, cmd_valid=0, powered=0, rd_done=0, busy=0, shadow=0x0000, synchronizer flops=1.
REQ-029 Reset released during a bus transaction SHALL keep the block in IDLE until the next START.

Configuration
REQ-030 With BH1750_TARGET_TIMEOUT_EN defined, a counter SHALL return any non-IDLE state to IDLE and release SDA after TIMEOUT_CYC cycles with no synchronized SCL edge; without it, no counter SHALL exist and the block SHALL wait indefinitely for START/STOP.

Verification
REQ-031 addr_sel=0, master writes 0x46 (0x23,W), 0x10, STOP -> both bytes ACKed, opcode=0x10, one cmd_valid pulse, powered=1.
REQ-032 powered=1, sample=0xA5C3, read 0x47 with ACK, NACK -> bytes 0xA5, 0xC3, one rd_done pulse, busy low after STOP.
REQ-033 addr_sel=1, master addresses 0x23 -> NACK on the 9th bit, SDA never driven, opcode unchanged.
REQ-034 write 0x00 then read 3 bytes with ACK,ACK,NACK, sample=0x1234 -> 0x00,0x00,0xFF; powered=0.
REQ-035 _rst low asserted mid-read after 4 data bits -> SDA high-Z immediately, all outputs at reset values, next valid transaction works.
REQ-036 BH1750_TARGET_TIMEOUT_EN, TIMEOUT_CYC=100, SCL held low 120 cycles mid-byte -> IDLE, SDA released; undefined -> state held.
